// File: rtl/msrv32_alu_bist.sv
// ---------------------------------------------------------------------------
// msrv32_alu_bist
//
// Built-in self-test sequencer for the msrv32_alu. In test mode it sits next
// to the ALU and drives the ALU's operand and opcode inputs. It produces
// pseudo-random operand pairs from a Galois LFSR and applies NUM_VECTORS pairs
// to every RV32I ALU opcode in a fixed order. Each ALU result is folded into a
// MISR signature. Software or a bench compares the final signature against a
// golden value. The ALU itself is not modified.
//
// Parameters
//   NUM_VECTORS  operand pairs applied per opcode (1..4096)
//   LFSR_SEED    operand LFSR seed; zero is replaced by 32'h0000_0001
//   MISR_SEED    signature value loaded at the start of every run
//
// Ports
//   ms_riscv32_mp_clk_in  in   1   clock, rising edge
//   ms_riscv32_mp_rst_in  in   1   synchronous active-high reset
//   start_in              in   1   begin a run (sampled in IDLE or DONE only)
//   result_in             in   32  msrv32_alu result_out
//   op1_out               out  32  to msrv32_alu op1_in
//   op2_out               out  32  to msrv32_alu op2_in
//   opcode_out            out  4   to msrv32_alu opcode_in, {funct7[5],funct3}
//   busy_out              out  1   high while a run is in progress
//   done_out              out  1   high once the run finished, until restart
//   signature_out         out  32  MISR contents, final when done_out=1
//   vec_count_out         out  16  vectors captured in the current run
// ---------------------------------------------------------------------------
module msrv32_alu_bist #(
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2345,
  parameter logic [31:0] MISR_SEED   = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        start_in,
  input  logic [31:0] result_in,
  output logic [31:0] op1_out,
  output logic [31:0] op2_out,
  output logic [3:0]  opcode_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] signature_out,
  output logic [15:0] vec_count_out
);

  // Sequencer states
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEED    = 3'd1;
  localparam logic [2:0] APPLY   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  // x^32 + x^22 + x^2 + x + 1. This polynomial is shared by the operand LFSR
  // and the signature MISR.
  localparam logic [31:0] POLY = 32'h0040_0007;

  // A zero seed would lock the LFSR at zero forever, so it is promoted to 1.
  localparam logic [31:0] LFSR_INIT = (LFSR_SEED == 32'h0) ? 32'h0000_0001 : LFSR_SEED;

  // Last vector index within one opcode, and last opcode index in the table.
  localparam logic [11:0] LAST_VEC = 12'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAST_OP  = 4'd9;

  logic [2:0]  state_q,    state_d;
  logic [31:0] lfsr_q,     lfsr_d;
  logic [31:0] sig_q,      sig_d;
  logic [31:0] op1_q,      op1_d;
  logic [31:0] op2_q,      op2_d;
  logic [3:0]  opcode_q,   opcode_d;
  logic [3:0]  opIdx_q,    opIdx_d;
  logic [11:0] vecIdx_q,   vecIdx_d;
  logic [15:0] vecCount_q, vecCount_d;

  // One Galois left-shift step. The MISR uses the same step and then XORs in
  // the captured result.
  function automatic logic [31:0] shiftPoly(input logic [31:0] s);
    shiftPoly = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
  endfunction

  // Fixed opcode sweep order: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  // The encoding is {funct7[5], funct3}, which is what msrv32_alu decodes.
  function automatic logic [3:0] opcodeFor(input logic [3:0] idx);
    case (idx)
      4'd0:    opcodeFor = 4'b0000;
      4'd1:    opcodeFor = 4'b1000;
      4'd2:    opcodeFor = 4'b0001;
      4'd3:    opcodeFor = 4'b0010;
      4'd4:    opcodeFor = 4'b0011;
      4'd5:    opcodeFor = 4'b0100;
      4'd6:    opcodeFor = 4'b0101;
      4'd7:    opcodeFor = 4'b1101;
      4'd8:    opcodeFor = 4'b0110;
      4'd9:    opcodeFor = 4'b0111;
      default: opcodeFor = 4'b0000;
    endcase
  endfunction

  // Next-state logic for the whole sequencer.
  // Each vector takes two cycles. On leaving APPLY, the operands and the
  // opcode are registered. During CAPTURE they are held for one full cycle so
  // that the combinational ALU settles. On leaving CAPTURE, the ALU result is
  // folded into the signature. Outputs come only from these registers, so
  // result_in has no combinational path to any output.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    sig_d      = sig_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opcode_d   = opcode_q;
    opIdx_d    = opIdx_q;
    vecIdx_d   = vecIdx_q;
    vecCount_d = vecCount_q;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = SEED;
        end
      end

      SEED: begin
        lfsr_d     = LFSR_INIT;
        sig_d      = MISR_SEED;
        opIdx_d    = 4'd0;
        vecIdx_d   = 12'd0;
        vecCount_d = 16'd0;
        state_d    = APPLY;
      end

      APPLY: begin
        op1_d    = lfsr_q;
        op2_d    = shiftPoly(lfsr_q);
        lfsr_d   = shiftPoly(shiftPoly(lfsr_q));
        opcode_d = opcodeFor(opIdx_q);
        state_d  = CAPTURE;
      end

      CAPTURE: begin
        sig_d      = shiftPoly(sig_q) ^ result_in;
        vecCount_d = vecCount_q + 16'd1;
        if (vecIdx_q == LAST_VEC) begin
          vecIdx_d = 12'd0;
          opIdx_d  = opIdx_q + 4'd1;
        end else begin
          vecIdx_d = vecIdx_q + 12'd1;
        end
        if ((opIdx_q == LAST_OP) && (vecIdx_q == LAST_VEC)) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
        end
      end

      DONE: begin
        if (start_in) begin
          state_d = SEED;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  // Reset wins at any time. If reset arrives during a run, the run is
  // abandoned and every visible register returns to zero, so no partial
  // signature survives.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= IDLE;
      lfsr_q     <= 32'h0;
      sig_q      <= 32'h0;
      op1_q      <= 32'h0;
      op2_q      <= 32'h0;
      opcode_q   <= 4'h0;
      opIdx_q    <= 4'h0;
      vecIdx_q   <= 12'h0;
      vecCount_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      sig_q      <= sig_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opcode_q   <= opcode_d;
      opIdx_q    <= opIdx_d;
      vecIdx_q   <= vecIdx_d;
      vecCount_q <= vecCount_d;
    end
  end

  // Output mapping. Status flags decode directly from the registered state.
  always_comb begin
    op1_out       = op1_q;
    op2_out       = op2_q;
    opcode_out    = opcode_q;
    signature_out = sig_q;
    vec_count_out = vecCount_q;
    busy_out      = (state_q == SEED) || (state_q == APPLY) || (state_q == CAPTURE);
    done_out      = (state_q == DONE);
  end

endmodule
